// File: rtl/b1_r2_sweep_checker.sv
// Sweeps all 8 input vectors of a b1_r2 block, compares responses after LATENCY cycles
// against a built-in golden model. Define B1R2_SWEEP_ABORT_EN to stop a run on the first mismatch.
module b1_r2_sweep_checker #(
    parameter int LATENCY = 0,
    parameter int PASSES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       po0,
    input  logic       po1,
    input  logic       po2,
    input  logic       po3,
    output logic       pi0,
    output logic       pi1,
    output logic       pi2,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail_vec,
    output logic [3:0] fail_mask
);

    localparam int WW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int PW = $clog2(PASSES) + 1;
    localparam logic [WW-1:0] WLOAD = WW'(LATENCY);
    localparam logic [PW-1:0] PLAST = PW'(PASSES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    state_t        state, state_n;
    logic [2:0]    vec, vec_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic [PW-1:0] pcnt, pcnt_n;
    logic          busy_n, done_n, pass_n;
    logic [3:0]    err_n, mask_n;
    logic [2:0]    ffv_n;
    logic [3:0]    golden, diff;
    logic          mismatch, abort;

    assign golden = {~vec[2],
                     (vec[0] & vec[1] & ~vec[2]) | (~vec[0] & ~vec[1] & vec[2]),
                     vec[0] ^ vec[1],
                     vec[2]};
    assign diff     = golden ^ {po3, po2, po1, po0};
    assign mismatch = |diff;

`ifdef B1R2_SWEEP_ABORT_EN
    assign abort = mismatch;
`else
    assign abort = 1'b0;
`endif

    assign pi0 = vec[0];
    assign pi1 = vec[1];
    assign pi2 = vec[2];

    always_comb begin
        state_n = state;
        vec_n   = vec;
        wcnt_n  = wcnt;
        pcnt_n  = pcnt;
        busy_n  = busy;
        done_n  = done;
        err_n   = err_count;
        mask_n  = fail_mask;
        ffv_n   = first_fail_vec;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = SETTLE;
                    vec_n   = 3'd0;
                    wcnt_n  = WLOAD;
                    pcnt_n  = '0;
                    busy_n  = 1'b1;
                    done_n  = 1'b0;
                    err_n   = 4'd0;
                    mask_n  = 4'd0;
                    ffv_n   = 3'd0;
                end
            end
            SETTLE: begin
                if (wcnt != '0) begin
                    wcnt_n = wcnt - WW'(1);
                end else begin
                    if (mismatch) begin
                        err_n  = (err_count == 4'd15) ? 4'd15 : err_count + 4'd1;
                        mask_n = fail_mask | diff;
                        // err_count never returns to zero within a run, so it marks the first miss
                        if (err_count == 4'd0) begin
                            ffv_n = vec;
                        end
                    end
                    if (abort || (vec == 3'd7 && pcnt == PLAST)) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        vec_n  = vec + 3'd1;
                        wcnt_n = WLOAD;
                        if (vec == 3'd7) begin
                            pcnt_n = pcnt + PW'(1);
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        pass_n = done_n & (err_n == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            vec            <= 3'd0;
            wcnt           <= '0;
            pcnt           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 4'd0;
            first_fail_vec <= 3'd0;
            fail_mask      <= 4'd0;
        end else begin
            state          <= state_n;
            vec            <= vec_n;
            wcnt           <= wcnt_n;
            pcnt           <= pcnt_n;
            busy           <= busy_n;
            done           <= done_n;
            pass           <= pass_n;
            err_count      <= err_n;
            first_fail_vec <= ffv_n;
            fail_mask      <= mask_n;
        end
    end

endmodule

// File: tb/tb_b1_r2_sweep_checker.sv
// Scoreboard bench for b1_r2_sweep_checker: four instances (L0/P1 with selectable faults,
// L1 and L2 on a 2-stage pipelined golden block, L0/P4 with po0 inverted).
module tb_b1_r2_sweep_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start_v = 4'd0;
    logic [1:0] mode = 2'd0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    wire  [3:0] busy_v, done_v, pass_v;
    wire  [3:0] err_v  [4];
    wire  [2:0] ffv_v  [4];
    wire  [3:0] mask_v [4];
    wire  [2:0] vec_v  [4];

    logic [3:0] po_c0, po_c1, po_c2, po_c3;
    logic [3:0] p1a = 4'd0, p1b = 4'd0, p2a = 4'd0, p2b = 4'd0;

    typedef struct {
        int         id;
        int         start_cyc;
        int         lat;
        bit         ps;
        logic [3:0] err;
        logic [2:0] ffv;
        logic [3:0] mask;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural b1_r2 used only as the block under test
    function automatic logic [3:0] model(input logic [2:0] v);
        return {~v[2], (v[0] & v[1] & ~v[2]) | (~v[0] & ~v[1] & v[2]), v[0] ^ v[1], v[2]};
    endfunction

    always_comb begin
        po_c0 = model(vec_v[0]);
        if (mode == 2'd1) po_c0[1] = 1'b0;
        if (mode == 2'd2) po_c0[2] = 1'b1;
    end

    always @(posedge clk) begin
        p1a <= model(vec_v[1]);
        p1b <= p1a;
        p2a <= model(vec_v[2]);
        p2b <= p2a;
    end

    assign po_c1 = p1b;
    assign po_c2 = p2b;
    assign po_c3 = model(vec_v[3]) ^ 4'b0001;

    b1_r2_sweep_checker #(.LATENCY(0), .PASSES(1)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]),
        .po0(po_c0[0]), .po1(po_c0[1]), .po2(po_c0[2]), .po3(po_c0[3]),
        .pi0(vec_v[0][0]), .pi1(vec_v[0][1]), .pi2(vec_v[0][2]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(err_v[0]), .first_fail_vec(ffv_v[0]), .fail_mask(mask_v[0]));

    b1_r2_sweep_checker #(.LATENCY(1), .PASSES(1)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]),
        .po0(po_c1[0]), .po1(po_c1[1]), .po2(po_c1[2]), .po3(po_c1[3]),
        .pi0(vec_v[1][0]), .pi1(vec_v[1][1]), .pi2(vec_v[1][2]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(err_v[1]), .first_fail_vec(ffv_v[1]), .fail_mask(mask_v[1]));

    b1_r2_sweep_checker #(.LATENCY(2), .PASSES(1)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]),
        .po0(po_c2[0]), .po1(po_c2[1]), .po2(po_c2[2]), .po3(po_c2[3]),
        .pi0(vec_v[2][0]), .pi1(vec_v[2][1]), .pi2(vec_v[2][2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_count(err_v[2]), .first_fail_vec(ffv_v[2]), .fail_mask(mask_v[2]));

    b1_r2_sweep_checker #(.LATENCY(0), .PASSES(4)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]),
        .po0(po_c3[0]), .po1(po_c3[1]), .po2(po_c3[2]), .po3(po_c3[3]),
        .pi0(vec_v[3][0]), .pi1(vec_v[3][1]), .pi2(vec_v[3][2]),
        .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]),
        .err_count(err_v[3]), .first_fail_vec(ffv_v[3]), .fail_mask(mask_v[3]));

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulses start on one instance; optionally records the expected end-of-run result
    task automatic applyStimulus(input int id, input int lat, input bit ps, input logic [3:0] e,
                                 input logic [2:0] f, input logic [3:0] m, input bit push);
        exp_t it;
        @(negedge clk);
        it.id = id; it.start_cyc = cyc + 1; it.lat = lat; it.ps = ps;
        it.err = e; it.ffv = f; it.mask = m;
        if (push) sb.push_back(it);
        start_v[id] = 1'b1;
        @(negedge clk);
        start_v[id] = 1'b0;
    endtask

    task automatic waitEmpty();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("run_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: on each rising done, pop the oldest expectation and compare
    logic [3:0] done_prev = 4'd0;
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_v[i] && !done_prev[i]) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", i, -1);
                end else begin
                    exp_t it;
                    it = sb.pop_front();
                    checkOutput("done_id", i, it.id);
                    checkOutput("done_latency", cyc - it.start_cyc, it.lat);
                    checkOutput("busy_at_done", int'(busy_v[i]), 0);
                    checkOutput("pass", int'(pass_v[i]), int'(it.ps));
                    checkOutput("err_count", int'(err_v[i]), int'(it.err));
                    checkOutput("first_fail_vec", int'(ffv_v[i]), int'(it.ffv));
                    checkOutput("fail_mask", int'(mask_v[i]), int'(it.mask));
                end
            end
        end
        done_prev <= done_v;
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", int'(busy_v[0]), 0);
        checkOutput("rst_done", int'(done_v[0]), 0);
        checkOutput("rst_pass", int'(pass_v[0]), 0);
        checkOutput("rst_err", int'(err_v[0]), 0);
        checkOutput("rst_ffv", int'(ffv_v[0]), 0);
        checkOutput("rst_mask", int'(mask_v[0]), 0);
        checkOutput("rst_vec", int'(vec_v[0]), 0);

        $display("[TB] golden sweep, LATENCY=0");
        mode = 2'd0;
        applyStimulus(0, 8, 1'b1, 4'd0, 3'd0, 4'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            checkOutput("pi_step", int'(vec_v[0]), k);
            checkOutput("busy_during", int'(busy_v[0]), 1);
            @(negedge clk);
        end
        waitEmpty();

`ifdef B1R2_SWEEP_ABORT_EN
        $display("[TB] po2 stuck at 1 with abort");
        mode = 2'd2;
        applyStimulus(0, 1, 1'b0, 4'd1, 3'd0, 4'b0100, 1'b1);
`else
        $display("[TB] po1 stuck at 0, restart from DONE");
        mode = 2'd1;
        applyStimulus(0, 8, 1'b0, 4'd4, 3'd1, 4'b0010, 1'b1);
`endif
        checkOutput("restart_done_low", int'(done_v[0]), 0);
        checkOutput("restart_busy_high", int'(busy_v[0]), 1);
        checkOutput("restart_err_clear", int'(err_v[0]), 0);
        waitEmpty();

        $display("[TB] reset mid-run at vec 4");
`ifdef B1R2_SWEEP_ABORT_EN
        mode = 2'd0;
`else
        mode = 2'd1;
`endif
        applyStimulus(0, 0, 1'b0, 4'd0, 3'd0, 4'd0, 1'b0);
        for (int i = 0; i < 20 && vec_v[0] != 3'd4; i++) @(negedge clk);
        checkOutput("reach_vec4", int'(vec_v[0]), 4);
        rst = 1'b1;
        start_v[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_v[0] = 1'b0;
        checkOutput("midrst_busy", int'(busy_v[0]), 0);
        checkOutput("midrst_done", int'(done_v[0]), 0);
        checkOutput("midrst_err", int'(err_v[0]), 0);
        checkOutput("midrst_mask", int'(mask_v[0]), 0);
        checkOutput("midrst_ffv", int'(ffv_v[0]), 0);
        checkOutput("midrst_vec", int'(vec_v[0]), 0);
        @(negedge clk);
        checkOutput("midrst_start_ignored", int'(busy_v[0]), 0);
        mode = 2'd0;
        applyStimulus(0, 8, 1'b1, 4'd0, 3'd0, 4'd0, 1'b1);
        waitEmpty();

        $display("[TB] 2-stage pipeline, LATENCY=2");
        applyStimulus(2, 24, 1'b1, 4'd0, 3'd0, 4'd0, 1'b1);
        waitEmpty();

        $display("[TB] 2-stage pipeline, LATENCY=1");
`ifdef B1R2_SWEEP_ABORT_EN
        applyStimulus(1, 4, 1'b0, 4'd1, 3'd1, 4'b0010, 1'b1);
`else
        applyStimulus(1, 16, 1'b0, 4'd5, 3'd1, 4'b1111, 1'b1);
`endif
        waitEmpty();

        $display("[TB] PASSES=4, po0 inverted");
`ifdef B1R2_SWEEP_ABORT_EN
        applyStimulus(3, 1, 1'b0, 4'd1, 3'd0, 4'b0001, 1'b1);
`else
        applyStimulus(3, 32, 1'b0, 4'd15, 3'd0, 4'b0001, 1'b1);
`endif
        waitEmpty();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
